// File: rtl/multicycle_control_fsm.sv
// Multi-cycle CPU datapath controller.
// Sequences fetch / decode / execute / memory / write-back per instruction,
// drives every datapath strobe and mux select, waits on the memory ready
// handshake and counts retired instructions.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_opcode           IR[31:26], valid from DECODE onward
//   i_mem_ready        memory finished the current read/write this cycle
//   o_pc_*             PC load strobes and PC source select
//   o_iord .. o_alu_op datapath strobes and mux selects
//   o_instr_done       one-cycle retire pulse
//   o_illegal_op       sticky undefined-opcode flag
//   o_instr_count      retired-instruction counter (wraps)
//   o_state            current state code for debug
module multicycle_control_fsm #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [5:0]         i_opcode,
    input  logic               i_mem_ready,
    output logic               o_pc_write,
    output logic               o_pc_write_eq,
    output logic               o_pc_write_ne,
    output logic [1:0]         o_pc_source,
    output logic               o_iord,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_ir_write,
    output logic               o_reg_write,
    output logic               o_reg_dst,
    output logic               o_mem_to_reg,
    output logic               o_alu_src_a,
    output logic [1:0]         o_alu_src_b,
    output logic [2:0]         o_alu_op,
    output logic               o_instr_done,
    output logic               o_illegal_op,
    output logic [COUNT_W-1:0] o_instr_count,
    output logic [3:0]         o_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [2:0] ALU_R    = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_ORI  = 3'b010;
    localparam logic [2:0] ALU_ANDI = 3'b011;
    localparam logic [2:0] ALU_SW   = 3'b100;
    localparam logic [2:0] ALU_LW   = 3'b101;
    localparam logic [2:0] ALU_BEQ  = 3'b110;
    localparam logic [2:0] ALU_BNE  = 3'b111;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_alu_op;     // operation class latched in DECODE
    logic               r_illegal;
    logic [COUNT_W-1:0] r_count;
    logic [2:0]         w_dec_alu_op;
    logic               w_illegal;
    logic               w_done;

    // Opcode decode: ALU class for the instruction and legality
    always_comb begin
        w_dec_alu_op = ALU_R;
        w_illegal    = 1'b0;
        if (i_opcode[5]) begin
            case (i_opcode)
                6'b100000: w_dec_alu_op = ALU_ADD;
                6'b100001: w_dec_alu_op = ALU_LW;
                6'b100010: w_dec_alu_op = ALU_SW;
                6'b100011: w_dec_alu_op = ALU_ANDI;
                6'b100100: w_dec_alu_op = ALU_ORI;
                6'b100101: w_dec_alu_op = ALU_BEQ;
                6'b100110: w_dec_alu_op = ALU_BNE;
                6'b111111: w_dec_alu_op = ALU_ADD;
                default:   w_illegal    = 1'b1;
            endcase
        end
    end

    // Next-state and retire pulse
    always_comb begin
        w_next = S_FETCH;
        w_done = 1'b0;
        case (r_state)
            S_FETCH:    w_next = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_illegal) begin
                    w_next = S_FETCH;
                    w_done = 1'b1;
                end else if (!i_opcode[5]) begin
                    w_next = S_EXEC_R;
                end else if (i_opcode == 6'b111111) begin
                    w_next = S_JUMP;
                end else begin
                    case (w_dec_alu_op)
                        ALU_LW, ALU_SW:   w_next = S_MEM_ADDR;
                        ALU_BEQ, ALU_BNE: w_next = S_BRANCH;
                        default:          w_next = S_EXEC_I;
                    endcase
                end
            end
            S_MEM_ADDR: w_next = (r_alu_op == ALU_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = i_mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   w_done = 1'b1;
            S_MEM_WR: begin
                w_next = i_mem_ready ? S_FETCH : S_MEM_WR;
                w_done = i_mem_ready;
            end
            S_EXEC_R:   w_next = S_R_WB;
            S_R_WB:     w_done = 1'b1;
            S_EXEC_I:   w_next = S_I_WB;
            S_I_WB:     w_done = 1'b1;
            S_BRANCH:   w_done = 1'b1;
            S_JUMP:     w_done = 1'b1;
            default:    w_next = S_FETCH;
        endcase
    end

    // State, latched op class, sticky illegal flag and retire counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_FETCH;
            r_alu_op  <= ALU_R;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_alu_op <= w_dec_alu_op;
                if (w_illegal) r_illegal <= 1'b1;
            end
            if (w_done) r_count <= r_count + COUNT_W'(1);
        end
    end

    // Moore output decode; FETCH and MEM_WR also follow the ready handshake
    always_comb begin
        o_pc_write    = 1'b0;
        o_pc_write_eq = 1'b0;
        o_pc_write_ne = 1'b0;
        o_pc_source   = 2'b00;
        o_iord        = 1'b0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_ir_write    = 1'b0;
        o_reg_write   = 1'b0;
        o_reg_dst     = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = 2'b00;
        o_alu_op      = 3'b000;
        o_instr_done  = w_done;
        case (r_state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = 2'b01;
                o_alu_op    = ALU_ADD;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b = 2'b11;
                o_alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_alu_op    = r_alu_op;
            end
            S_MEM_RD: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_mem_write = 1'b1;
                o_iord      = 1'b1;
            end
            S_EXEC_R:   o_alu_src_a = 1'b1;
            S_R_WB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_I_WB:     o_reg_write = 1'b1;
            S_BRANCH: begin
                o_alu_src_a   = 1'b1;
                o_alu_op      = r_alu_op;
                o_pc_source   = 2'b01;
                o_pc_write_eq = (r_alu_op == ALU_BEQ);
                o_pc_write_ne = (r_alu_op == ALU_BNE);
            end
            S_JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = 2'b10;
            end
            default: ;
        endcase
        // Reset silences every strobe and select irrespective of state
        if (i_rst) begin
            o_pc_write    = 1'b0;
            o_pc_write_eq = 1'b0;
            o_pc_write_ne = 1'b0;
            o_pc_source   = 2'b00;
            o_iord        = 1'b0;
            o_mem_read    = 1'b0;
            o_mem_write   = 1'b0;
            o_ir_write    = 1'b0;
            o_reg_write   = 1'b0;
            o_reg_dst     = 1'b0;
            o_mem_to_reg  = 1'b0;
            o_alu_src_a   = 1'b0;
            o_alu_src_b   = 2'b00;
            o_alu_op      = 3'b000;
            o_instr_done  = 1'b0;
        end
    end

    assign o_illegal_op  = r_illegal;
    assign o_instr_count = r_count;
    assign o_state       = r_state;

endmodule
